// File: rtl/battlegrid_draw.sv
// battlegrid_draw
//   Pixel-drawing engine for the BattleChip VGA path. It renders N boards with
//   configurable geometry. Commands arrive on a valid/ready handshake. Each
//   busy cycle produces one pixel on VGA_X/VGA_Y/VGA_COLOUR/VGA_PLOT.
//
// Ports
//   CLOCK_50    : system clock, rising edge
//   reset       : synchronous, active-high reset
//   cmd_valid   : command present
//   cmd_ready   : engine idle, command will be accepted this edge
//   cmd_op      : 0=CLEAR, 1=GRID, 2=FILL_CELL, 3=reserved (rejected)
//   cmd_board   : board index
//   cmd_row     : cell row    (FILL_CELL)
//   cmd_col     : cell column (FILL_CELL)
//   cmd_colour  : colour to draw
//   done        : one-cycle pulse when a command completes
//   err         : one-cycle pulse with done for a rejected command
//   VGA_X/VGA_Y : pixel coordinate
//   VGA_COLOUR  : pixel colour
//   VGA_PLOT    : write strobe for the current pixel
module battlegrid_draw #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int GRID_N      = 10,
  parameter int CELL_PX     = 14,
  parameter int NUM_BOARDS  = 2,
  parameter int BOARD_X0    = 10,
  parameter int BOARD_PITCH = 160,
  parameter int BOARD_Y     = 50,
  parameter int COL_W       = 3,
  localparam int BOARD_W    = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [BOARD_W-1:0] cmd_board,
  input  logic [3:0]         cmd_row,
  input  logic [3:0]         cmd_col,
  input  logic [COL_W-1:0]   cmd_colour,
  output logic               done,
  output logic               err,
  output logic [X_W-1:0]     VGA_X,
  output logic [Y_W-1:0]     VGA_Y,
  output logic [COL_W-1:0]   VGA_COLOUR,
  output logic               VGA_PLOT
);

  // Board side in pixels, including the closing gridline.
  localparam int SIDE   = GRID_N * CELL_PX + 1;
  localparam int CNT_W  = $clog2(SIDE);
  localparam int CELL_W = $clog2(CELL_PX);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_GRID  = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    GRID  = 3'd2,
    CELL  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   dx_reg;      // GRID: dx; CELL: interior i
  logic [CNT_W-1:0]   dy_reg;      // GRID: dy; CELL: interior j
  logic [CELL_W-1:0]  cx_reg;      // dx modulo CELL_PX
  logic [CELL_W-1:0]  cy_reg;      // dy modulo CELL_PX
  logic [X_W-1:0]     row_x0_reg;  // x where each scan row restarts

  logic [X_W-1:0]     acc_ox;
  logic [X_W-1:0]     acc_cell_x;
  logic [Y_W-1:0]     acc_cell_y;
  logic               acc_bad;
  logic [CELL_W-1:0]  cx_next;
  logic [CELL_W-1:0]  cy_next;

  assign cmd_ready = (state_reg == IDLE) && !reset;

  // Geometry and validation of the command on the input pins. It is only
  // consumed at the accepting edge.
  always_comb begin
    acc_ox     = X_W'(BOARD_X0 + int'(cmd_board) * BOARD_PITCH);
    acc_cell_x = X_W'(BOARD_X0 + int'(cmd_board) * BOARD_PITCH
                      + int'(cmd_col) * CELL_PX + 1);
    acc_cell_y = Y_W'(BOARD_Y + int'(cmd_row) * CELL_PX + 1);
    acc_bad    = 1'b0;
    if (cmd_op == 2'd3)
      acc_bad = 1'b1;
    if ((cmd_op == OP_GRID || cmd_op == OP_FILL) && int'(cmd_board) >= NUM_BOARDS)
      acc_bad = 1'b1;
    if (cmd_op == OP_FILL && (int'(cmd_row) >= GRID_N || int'(cmd_col) >= GRID_N))
      acc_bad = 1'b1;
  end

  // Cell-local wrap counters. A gridline falls wherever one of them is zero,
  // so no divider is needed.
  always_comb begin
    cx_next = (cx_reg == CELL_W'(CELL_PX - 1)) ? '0 : cx_reg + 1'b1;
    cy_next = (cy_reg == CELL_W'(CELL_PX - 1)) ? '0 : cy_reg + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      VGA_X      <= '0;
      VGA_Y      <= '0;
      VGA_COLOUR <= '0;
      VGA_PLOT   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      row_x0_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done     <= 1'b0;
          err      <= 1'b0;
          VGA_PLOT <= 1'b0;
          if (cmd_valid) begin
            VGA_COLOUR <= cmd_colour;
            dx_reg     <= '0;
            dy_reg     <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            if (acc_bad) begin
              state_reg <= FIN;
              done      <= 1'b1;
              err       <= 1'b1;
            end else begin
              case (cmd_op)
                OP_CLEAR: begin
                  state_reg <= CLEAR;
                  VGA_X     <= '0;
                  VGA_Y     <= '0;
                  VGA_PLOT  <= 1'b1;
                end
                OP_GRID: begin
                  state_reg  <= GRID;
                  VGA_X      <= acc_ox;
                  VGA_Y      <= Y_W'(BOARD_Y);
                  row_x0_reg <= acc_ox;
                  VGA_PLOT   <= 1'b1;     // (0,0) is a gridline corner
                end
                default: begin            // OP_FILL; op 3 was rejected above
                  state_reg  <= CELL;
                  VGA_X      <= acc_cell_x;
                  VGA_Y      <= acc_cell_y;
                  row_x0_reg <= acc_cell_x;
                  VGA_PLOT   <= 1'b1;
                end
              endcase
            end
          end
        end

        CLEAR: begin
          if (VGA_X == X_W'(SCREEN_W - 1)) begin
            if (VGA_Y == Y_W'(SCREEN_H - 1)) begin
              state_reg <= FIN;
              VGA_PLOT  <= 1'b0;
              done      <= 1'b1;
            end else begin
              VGA_X <= '0;
              VGA_Y <= VGA_Y + 1'b1;
            end
          end else begin
            VGA_X <= VGA_X + 1'b1;
          end
        end

        GRID: begin
          if (dx_reg == CNT_W'(SIDE - 1)) begin
            if (dy_reg == CNT_W'(SIDE - 1)) begin
              state_reg <= FIN;
              VGA_PLOT  <= 1'b0;
              done      <= 1'b1;
            end else begin
              dx_reg   <= '0;
              cx_reg   <= '0;
              dy_reg   <= dy_reg + 1'b1;
              cy_reg   <= cy_next;
              VGA_X    <= row_x0_reg;
              VGA_Y    <= VGA_Y + 1'b1;
              VGA_PLOT <= 1'b1;           // dx = 0 is always a vertical line
            end
          end else begin
            dx_reg   <= dx_reg + 1'b1;
            cx_reg   <= cx_next;
            VGA_X    <= VGA_X + 1'b1;
            VGA_PLOT <= (cx_next == '0) || (cy_reg == '0);
          end
        end

        CELL: begin
          if (dx_reg == CNT_W'(CELL_PX - 2)) begin
            if (dy_reg == CNT_W'(CELL_PX - 2)) begin
              state_reg <= FIN;
              VGA_PLOT  <= 1'b0;
              done      <= 1'b1;
            end else begin
              dx_reg <= '0;
              dy_reg <= dy_reg + 1'b1;
              VGA_X  <= row_x0_reg;
              VGA_Y  <= VGA_Y + 1'b1;
            end
          end else begin
            dx_reg <= dx_reg + 1'b1;
            VGA_X  <= VGA_X + 1'b1;
          end
        end

        FIN: begin
          done      <= 1'b0;
          err       <= 1'b0;
          VGA_PLOT  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          VGA_PLOT  <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/battlegrid_draw.md
Name: battlegrid_draw

Overview:
- Parametrised pixel-drawing engine for the BattleChip VGA path; generalises the fixed single-board screen drawer to N-board, configurable-geometry rendering.
- Accepts commands over a valid/ready handshake: clear screen, draw one board's grid lines, or fill one cell.
- Emits one pixel per cycle on an x/y/colour/plot interface that feeds the VGA adapter.

Parameters:
- SCREEN_W, 320, screen width in pixels.
- SCREEN_H, 240, screen height in pixels.
- X_W, 9, x coordinate width; must satisfy 2**X_W >= SCREEN_W.
- Y_W, 8, y coordinate width; must satisfy 2**Y_W >= SCREEN_H.
- GRID_N, 10, cells per board side.
- CELL_PX, 14, cell pitch in pixels, with gridline included; minimum 3.
- NUM_BOARDS, 2, number of boards.
- BOARD_X0, 10, x origin of board 0.
- BOARD_PITCH, 160, x distance between the origins of adjacent boards.
- BOARD_Y, 50, y origin of all boards.
- COL_W, 3, colour width.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_op  in  2  0=CLEAR, 1=GRID, 2=FILL_CELL, 3=reserved.
- cmd_board  in  $clog2(NUM_BOARDS) (minimum 1)  board index.
- cmd_row  in  4  cell row (0..GRID_N-1).
- cmd_col  in  4  cell column (0..GRID_N-1).
- cmd_colour  in  COL_W  colour to draw.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse, coincident with done, for a rejected command.
- VGA_X  out  X_W  pixel x.
- VGA_Y  out  Y_W  pixel y.
- VGA_COLOUR  out  COL_W  pixel colour.
- VGA_PLOT  out  1  write strobe for the current VGA_X/VGA_Y/VGA_COLOUR.

Behaviour:
- Reset, in the cycle reset is sampled high:
  - State goes to IDLE.
  - VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT, done, err all go to 0.
  - cmd_ready is 0 while reset is high and 1 in the first cycle after it.
  - Reset mid-command aborts the command immediately with no done pulse.
- States: IDLE, CLEAR, GRID, CELL, FIN.
- Accept rule: a command is accepted at the edge where cmd_valid && cmd_ready. All cmd_* fields are latched at that edge. cmd_ready is 0 in every state except IDLE.
- Board geometry: board b has origin OX = BOARD_X0 + b*BOARD_PITCH, OY = BOARD_Y. Side S = GRID_N*CELL_PX + 1.
- Validation is done at acceptance. The command is rejected if any of these holds:
  - op = 3;
  - for GRID or FILL_CELL, board >= NUM_BOARDS;
  - for FILL_CELL, row >= GRID_N or col >= GRID_N.
- Rejected command: go to FIN; no pixels are plotted; done=1 and err=1 in the cycle after acceptance.
- CLEAR: scan x = 0..SCREEN_W-1 (fastest-varying), then y = 0..SCREEN_H-1. VGA_PLOT=1 on every pixel, SCREEN_W*SCREEN_H cycles total (76800 at defaults).
- GRID: scan dx = 0..S-1 (fastest-varying), then dy = 0..S-1.
  - Output pixel is (OX+dx, OY+dy).
  - VGA_PLOT=1 only where dx%CELL_PX==0 or dy%CELL_PX==0; VGA_PLOT=0 otherwise, and the scan still advances.
  - S*S cycles total.
  - Implementation uses cell-local wrap counters; no dividers.
- FILL_CELL: fill the cell interior only, leaving gridlines intact.
  - x = OX + col*CELL_PX + 1 + i and y = OY + row*CELL_PX + 1 + j, for i, j = 0..CELL_PX-2, with i fastest-varying.
  - VGA_PLOT=1 throughout; (CELL_PX-1)**2 cycles total.
- Latency:
  - The first pixel is presented on VGA_X/VGA_Y/VGA_PLOT in the cycle after acceptance. All VGA outputs are registered.
  - The last pixel cycle is followed by FIN. In FIN: done=1, VGA_PLOT=0, cmd_ready=0.
  - The next cycle returns to IDLE with cmd_ready=1.
- VGA_COLOUR equals the latched cmd_colour during a command and holds its last value in IDLE.
- Command inputs that change while busy are ignored. cmd_valid while busy stalls with no effect.
- Coordinates never exceed SCREEN_W-1 / SCREEN_H-1 for legal parameterisations; this is the integrator's responsibility and is not checked in RTL.

Test Plan:
- Reset, then CLEAR with colour 3'b000 → exactly 76800 VGA_PLOT cycles. The first pixel is (0,0) in the cycle after acceptance; the last is (319,239). done pulses once; cmd_ready returns 1 the cycle after done.
- GRID with board 1, colour 3'b111 → scan box from (170,50) to (310,190), 141*141 = 19881 cycles. Plot is asserted at (184,51) and (171,64); not asserted at (171,51). The plot count equals 11*141*2 - 121 = 2981.
- FILL_CELL with board 0, row 5, col 9, colour 3'b100 → 169 pixels from (137,121) to (149,133); done follows the last pixel at (149,133).
- FILL_CELL with row 10 (and separately board 2 at NUM_BOARDS=2, and separately op=3) → no plot. done=1 and err=1 in the cycle after acceptance.
- Assert reset mid-CLEAR at pixel 1000 → VGA_PLOT=0 in the next cycle; no done pulse. cmd_ready=1 after reset deasserts; a new FILL_CELL then completes normally.
- Hold cmd_valid high with changing fields during GRID → only the first command executes. The second is accepted in the cycle after FIN, when cmd_ready is high.
